// File: rtl/freq_peak_search_pkg.sv
// Shared definitions for the frequency peak search controller.
//   FREQ_W  : width of the DDS frequency word
//   IQ_W    : width of the signed I/Q samples from the synth core
//   MAG_W   : width of one unsigned I*I+Q*Q magnitude sample
//   CNT_W   : width of the settle/measure/capture cycle counter
//   state_t : controller FSM state encoding (3 bits)
package freq_peak_search_pkg;

    localparam int FREQ_W = 14;
    localparam int IQ_W   = 10;
    localparam int MAG_W  = 2 * IQ_W;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_NEXT    = 3'd3,
        ST_RETUNE  = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_LOCK    = 3'd6
    } state_t;

endpackage

// File: rtl/freq_peak_search_mag_sq.sv
// Registered magnitude-squared of a signed I/Q pair, one cycle latency.
// Ports:
//   clk   in   system clock
//   rst   in   async reset, active-high (clears the valid flag only)
//   i_vld in   input sample valid
//   i_i   in   signed I sample
//   i_q   in   signed Q sample
//   o_sq  out  unsigned I*I+Q*Q
//   o_vld out  o_sq valid, i_vld delayed by one cycle
module mag_sq
    import freq_peak_search_pkg::*;
#(
    parameter int DATA_W = IQ_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_vld,
    input  logic signed [DATA_W-1:0]   i_i,
    input  logic signed [DATA_W-1:0]   i_q,
    output logic        [2*DATA_W-1:0] o_sq,
    output logic                       o_vld
);

    logic signed [2*DATA_W-1:0] w_i_ext_p0;
    logic signed [2*DATA_W-1:0] w_q_ext_p0;
    logic signed [2*DATA_W-1:0] w_ii_p0;
    logic signed [2*DATA_W-1:0] w_qq_p0;
    logic        [2*DATA_W-1:0] r_sq_p1;
    logic                       r_vld_p1;

    assign w_i_ext_p0 = (2*DATA_W)'(i_i);
    assign w_q_ext_p0 = (2*DATA_W)'(i_q);
    assign w_ii_p0    = w_i_ext_p0 * w_i_ext_p0;
    assign w_qq_p0    = w_q_ext_p0 * w_q_ext_p0;

    // ---- stage p0 -> p1 ----
    // Both squares are non-negative; their sum can reach 2^(2*DATA_W-1),
    // which only fits when the sum is treated as unsigned.
    always_ff @(posedge clk) begin
        r_sq_p1 <= $unsigned(w_ii_p0) + $unsigned(w_qq_p0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= i_vld;
        end
    end

    assign o_sq  = r_sq_p1;
    assign o_vld = r_vld_p1;

endmodule

// File: rtl/freq_peak_search.sv
// Upstream controller for the single-frequency synth core. Sweeps the DDS
// frequency word over a grid, measures averaged I^2+Q^2 at each point,
// retunes to the strongest point, captures averaged I/Q there and then
// switches the core to output the rebuilt tone.
// Ports:
//   clk       in   system clock
//   rst       in   async reset, active-high
//   start     in   one-cycle sweep request (honoured in IDLE and LOCK)
//   I, Q      in   signed filtered I/Q from the synth core
//   freq      out  frequency word to the core / DDS
//   ctrl      out  1 = core outputs rebuilt signal (locked)
//   I_o, Q_o  out  captured signed I/Q reference
//   busy      out  high from sweep start until lock
//   done      out  one-cycle pulse on entry to LOCK
//   peak_freq out  best frequency found
//   peak_mag  out  accumulated magnitude at peak_freq
module freq_peak_search
    import freq_peak_search_pkg::*;
#(
    parameter logic [FREQ_W-1:0] F_START    = 14'd100,
    parameter logic [FREQ_W-1:0] F_STOP     = 14'd8000,
    parameter logic [FREQ_W-1:0] F_STEP     = 14'd50,
    parameter logic [CNT_W-1:0]  SETTLE_CYC = 16'd2048,
    parameter int                AVG_LOG2   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic signed [IQ_W-1:0]     I,
    input  logic signed [IQ_W-1:0]     Q,
    output logic [FREQ_W-1:0]          freq,
    output logic                       ctrl,
    output logic signed [IQ_W-1:0]     I_o,
    output logic signed [IQ_W-1:0]     Q_o,
    output logic                       busy,
    output logic                       done,
    output logic [FREQ_W-1:0]          peak_freq,
    output logic [MAG_W+AVG_LOG2-1:0]  peak_mag
);

    localparam int              ACC_W       = MAG_W + AVG_LOG2;
    localparam int              SUM_W       = IQ_W + AVG_LOG2;
    localparam logic [CNT_W-1:0] AVG_N       = CNT_W'(1 << AVG_LOG2);
    localparam logic [CNT_W-1:0] AVG_LAST    = AVG_N - CNT_W'(1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = SETTLE_CYC - CNT_W'(1);

    // Sign-extend one sample to the capture-sum width.
    function automatic logic signed [SUM_W-1:0] sext_iq(input logic signed [IQ_W-1:0] x);
        return SUM_W'(x);
    endfunction

    // Divide a capture sum by 2^AVG_LOG2, rounding toward minus infinity.
    function automatic logic signed [IQ_W-1:0] avg_shift(input logic signed [SUM_W-1:0] s);
        logic signed [SUM_W-1:0] t;
        t = s >>> AVG_LOG2;
        return t[IQ_W-1:0];
    endfunction

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [CNT_W-1:0]          r_cnt;

    logic [FREQ_W-1:0]         r_freq;
    logic [FREQ_W-1:0]         r_peak_freq;
    logic [ACC_W-1:0]          r_peak_mag;
    logic                      r_ctrl;
    logic                      r_busy;
    logic                      r_done;
    logic signed [IQ_W-1:0]    r_i_o;
    logic signed [IQ_W-1:0]    r_q_o;

    logic [ACC_W-1:0]          r_acc;
    logic signed [SUM_W-1:0]   r_sum_i;
    logic signed [SUM_W-1:0]   r_sum_q;
    logic signed [SUM_W-1:0]   w_sum_i_nxt;
    logic signed [SUM_W-1:0]   w_sum_q_nxt;

    logic [MAG_W-1:0]          w_sq;
    logic                      w_sq_vld;
    logic                      w_meas;
    logic [FREQ_W:0]           w_freq_step;
    logic                      w_sweep_end;
    logic                      w_better;
    logic                      w_launch;
    logic                      w_settle_last;
    logic                      w_meas_last;
    logic                      w_cap_last;

    // Only samples taken while measuring are marked valid, so the first
    // MEASURE cycle sees an invalid (priming) magnitude.
    assign w_meas = (r_state == ST_MEASURE);

    mag_sq #(
        .DATA_W (IQ_W)
    ) u_mag_sq (
        .clk   (clk),
        .rst   (rst),
        .i_vld (w_meas),
        .i_i   (I),
        .i_q   (Q),
        .o_sq  (w_sq),
        .o_vld (w_sq_vld)
    );

    // The step is compared one bit wider so a sweep near the top of the
    // 14-bit range cannot wrap back into the grid.
    assign w_freq_step   = {1'b0, r_freq} + {1'b0, F_STEP};
    assign w_sweep_end   = (w_freq_step > {1'b0, F_STOP});
    assign w_better      = (r_acc > r_peak_mag);
    assign w_launch      = start && ((r_state == ST_IDLE) || (r_state == ST_LOCK));
    assign w_settle_last = (r_cnt == SETTLE_LAST);
    assign w_meas_last   = (r_cnt == AVG_N);
    assign w_cap_last    = (r_cnt == AVG_LAST);
    assign w_sum_i_nxt   = r_sum_i + sext_iq(I);
    assign w_sum_q_nxt   = r_sum_q + sext_iq(Q);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_launch)      w_state_nxt = ST_SETTLE;
            ST_SETTLE:  if (w_settle_last) w_state_nxt = ST_MEASURE;
            ST_MEASURE: if (w_meas_last)   w_state_nxt = ST_NEXT;
            ST_NEXT:    w_state_nxt = w_sweep_end ? ST_RETUNE : ST_SETTLE;
            ST_RETUNE:  if (w_settle_last) w_state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (w_cap_last)    w_state_nxt = ST_LOCK;
            ST_LOCK:    if (w_launch)      w_state_nxt = ST_SETTLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The counter restarts on every state change, so each timed state
    // counts from zero on entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if ((w_state_nxt != r_state) || (r_state == ST_IDLE) || (r_state == ST_LOCK)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // ---- accumulate stage: magnitude and capture sums ----
    // Cleared whenever their state is not active, so no reset is needed.
    always_ff @(posedge clk) begin
        if (!w_meas) begin
            r_acc <= '0;
        end else if (w_sq_vld) begin
            r_acc <= r_acc + ACC_W'(w_sq);
        end
        if (r_state != ST_CAPTURE) begin
            r_sum_i <= '0;
            r_sum_q <= '0;
        end else begin
            r_sum_i <= w_sum_i_nxt;
            r_sum_q <= w_sum_q_nxt;
        end
    end

    // ---- decision / output stage ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_freq      <= F_START;
            r_peak_freq <= F_START;
            r_peak_mag  <= '0;
            r_ctrl      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_i_o       <= '0;
            r_q_o       <= '0;
        end else begin
            r_done <= 1'b0;

            if (w_launch) begin
                r_freq      <= F_START;
                r_peak_freq <= F_START;
                r_peak_mag  <= '0;
                r_ctrl      <= 1'b0;
                r_busy      <= 1'b1;
            end

            if (r_state == ST_NEXT) begin
                // Strict compare: on a tie the earlier, lower frequency wins.
                if (w_better) begin
                    r_peak_mag  <= r_acc;
                    r_peak_freq <= r_freq;
                end
                // Retune uses the peak as updated by this same decision.
                if (w_sweep_end) begin
                    r_freq <= w_better ? r_freq : r_peak_freq;
                end else begin
                    r_freq <= w_freq_step[FREQ_W-1:0];
                end
            end

            if ((r_state == ST_CAPTURE) && w_cap_last) begin
                r_i_o  <= avg_shift(w_sum_i_nxt);
                r_q_o  <= avg_shift(w_sum_q_nxt);
                r_ctrl <= 1'b1;
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign freq      = r_freq;
    assign ctrl      = r_ctrl;
    assign I_o       = r_i_o;
    assign Q_o       = r_q_o;
    assign busy      = r_busy;
    assign done      = r_done;
    assign peak_freq = r_peak_freq;
    assign peak_mag  = r_peak_mag;

endmodule

// File: tb/tb_freq_peak_search.sv
// Bench for freq_peak_search: two instances share clock, reset and start.
// Instance A sweeps 100..300, instance B has an off-grid stop of 350.
// Each instance's I/Q input is a constant-per-frequency model.
module tb_freq_peak_search;

    typedef struct {
        int pf;
        int pm;
        int io;
    } res_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    int                 pat = 0;

    logic signed [9:0]  I_a, Q_a, I_b, Q_b;
    logic [13:0]        freq_a, freq_b, pf_a, pf_b;
    logic               ctrl_a, ctrl_b, busy_a, busy_b, done_a, done_b;
    logic signed [9:0]  Io_a, Qo_a, Io_b, Qo_b;
    logic [21:0]        pm_a, pm_b;

    int                 n_checks = 0;
    int                 n_errors = 0;
    int                 q_freq_a[$];
    int                 q_freq_b[$];
    res_t               q_res_a[$];
    res_t               q_res_b[$];
    int                 exp_last_a = 100;
    int                 exp_last_b = 100;
    int                 ndone_a = 0;
    int                 ndone_b = 0;
    int                 exp_done = 0;
    bit                 mon_en = 1'b0;
    logic [13:0]        last_a = 14'd100;
    logic [13:0]        last_b = 14'd100;
    logic               done_prev_a = 1'b0;
    logic               done_prev_b = 1'b0;

    always #5 clk = ~clk;

    function automatic logic signed [9:0] iqv(input logic [13:0] f, input int p);
        case (p)
            1:       return (f == 14'd200) ? 10'sd100 : 10'sd10;
            2:       return 10'sd50;
            3:       return (f == 14'd300) ? 10'h200 : 10'sd0;
            default: return 10'sd0;
        endcase
    endfunction

    assign I_a = iqv(freq_a, pat);
    assign Q_a = iqv(freq_a, pat);
    assign I_b = iqv(freq_b, pat);
    assign Q_b = iqv(freq_b, pat);

    freq_peak_search #(
        .F_START(14'd100), .F_STOP(14'd300), .F_STEP(14'd100),
        .SETTLE_CYC(16'd4), .AVG_LOG2(2)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .I(I_a), .Q(Q_a),
        .freq(freq_a), .ctrl(ctrl_a), .I_o(Io_a), .Q_o(Qo_a),
        .busy(busy_a), .done(done_a), .peak_freq(pf_a), .peak_mag(pm_a)
    );

    freq_peak_search #(
        .F_START(14'd100), .F_STOP(14'd350), .F_STEP(14'd100),
        .SETTLE_CYC(16'd4), .AVG_LOG2(2)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .I(I_b), .Q(Q_b),
        .freq(freq_b), .ctrl(ctrl_b), .I_o(Io_b), .Q_o(Qo_b),
        .busy(busy_b), .done(done_b), .peak_freq(pf_b), .peak_mag(pm_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Reference: best grid point by strict magnitude compare (4 samples of I^2+Q^2).
    function automatic res_t model(input int stop, input int p);
        res_t r;
        int   best;
        int   v;
        int   m;
        best = -1;
        r.pf = 100; r.pm = 0; r.io = 0;
        for (int f = 100; f <= stop; f += 100) begin
            v = int'(iqv(14'(f), p));
            m = 4 * 2 * v * v;
            if (m > best) begin
                best = m; r.pf = f; r.pm = m; r.io = v;
            end
        end
        return r;
    endfunction

    task automatic push_sweep(input int p);
        res_t ra, rb;
        ra = model(300, p);
        rb = model(350, p);
        q_res_a.push_back(ra);
        q_res_b.push_back(rb);
        for (int f = 100; f <= 300; f += 100) begin
            if (f != exp_last_a) q_freq_a.push_back(f);
            exp_last_a = f;
        end
        if (ra.pf != exp_last_a) q_freq_a.push_back(ra.pf);
        exp_last_a = ra.pf;
        for (int f = 100; f <= 350; f += 100) begin
            if (f != exp_last_b) q_freq_b.push_back(f);
            exp_last_b = f;
        end
        if (rb.pf != exp_last_b) q_freq_b.push_back(rb.pf);
        exp_last_b = rb.pf;
        exp_done++;
    endtask

    task automatic monitor();
        res_t r;
        if (mon_en) begin
            if (freq_a != last_a) begin
                if (q_freq_a.size() == 0) chk("a_freq_extra", 32'(freq_a), 0);
                else chk("a_freq_seq", 32'(freq_a), 32'(q_freq_a.pop_front()));
            end
            if (freq_b != last_b) begin
                chk("b_freq_max", 32'(freq_b > 14'd350), 0);
                if (q_freq_b.size() == 0) chk("b_freq_extra", 32'(freq_b), 0);
                else chk("b_freq_seq", 32'(freq_b), 32'(q_freq_b.pop_front()));
            end
            if (done_a) begin
                ndone_a++;
                if (q_res_a.size() == 0) chk("a_done_extra", 1, 0);
                else begin
                    r = q_res_a.pop_front();
                    chk("a_peak_freq", 32'(pf_a), 32'(r.pf));
                    chk("a_peak_mag", 32'(pm_a), 32'(r.pm));
                    chk("a_I_o", 32'(Io_a), 32'(r.io));
                    chk("a_Q_o", 32'(Qo_a), 32'(r.io));
                    chk("a_lock_freq", 32'(freq_a), 32'(r.pf));
                    chk("a_ctrl", 32'(ctrl_a), 1);
                    chk("a_busy", 32'(busy_a), 0);
                end
            end
            if (done_b) begin
                ndone_b++;
                if (q_res_b.size() == 0) chk("b_done_extra", 1, 0);
                else begin
                    r = q_res_b.pop_front();
                    chk("b_peak_freq", 32'(pf_b), 32'(r.pf));
                    chk("b_peak_mag", 32'(pm_b), 32'(r.pm));
                    chk("b_I_o", 32'(Io_b), 32'(r.io));
                end
            end
            if (done_prev_a) chk("a_done_width", 32'(done_a), 0);
            if (done_prev_b) chk("b_done_width", 32'(done_b), 0);
        end
        last_a = freq_a;
        last_b = freq_b;
        done_prev_a = done_a;
        done_prev_b = done_b;
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (((ndone_a < exp_done) || (ndone_b < exp_done)) && (n < 400)) begin
            tick();
            n++;
        end
        chk("a_done_seen", 32'(ndone_a), 32'(exp_done));
        chk("b_done_seen", 32'(ndone_b), 32'(exp_done));
        tick();
    endtask

    task automatic wait_freq_a(input int f);
        int n;
        n = 0;
        while ((int'(freq_a) != f) && (n < 200)) begin
            tick();
            n++;
        end
        chk("a_reach_freq", 32'(freq_a), 32'(f));
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_freq"}, 32'(freq_a), 100);
        chk({tag, "_ctrl"}, 32'(ctrl_a), 0);
        chk({tag, "_busy"}, 32'(busy_a), 0);
        chk({tag, "_done"}, 32'(done_a), 0);
        chk({tag, "_I_o"}, 32'(Io_a), 0);
        chk({tag, "_Q_o"}, 32'(Qo_a), 0);
        chk({tag, "_peak_mag"}, 32'(pm_a), 0);
        chk({tag, "_peak_freq"}, 32'(pf_a), 100);
    endtask

    initial begin
        // Power-on reset
        rst = 1'b1;
        repeat (3) tick();
        reset_checks("rst0");
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // Peak at 200
        pat = 1;
        push_sweep(1);
        pulse_start();
        chk("a_busy_start", 32'(busy_a), 1);
        wait_done();

        // Reset in the middle of measuring at 200, then a clean tie sweep
        pat = 2;
        push_sweep(2);
        pulse_start();
        wait_freq_a(200);
        repeat (6) tick();
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1 reset_checks("rst_mid");
        start = 1'b1;
        tick();
        tick();
        reset_checks("rst_hold");
        start = 1'b0;
        rst = 1'b0;
        q_freq_a.delete();
        q_freq_b.delete();
        q_res_a.delete();
        q_res_b.delete();
        exp_last_a = 100;
        exp_last_b = 100;
        exp_done = ndone_a;
        tick();
        chk("a_idle_after_rst", 32'(busy_a), 0);
        mon_en = 1'b1;
        push_sweep(2);
        pulse_start();
        wait_done();

        // Full-scale negative samples at the last grid point
        pat = 3;
        push_sweep(3);
        pulse_start();
        wait_done();

        // Start during SETTLE is ignored; start in LOCK relaunches
        pat = 1;
        push_sweep(1);
        pulse_start();
        wait_freq_a(200);
        tick();
        pulse_start();
        wait_done();
        push_sweep(1);
        pulse_start();
        chk("a_relaunch_ctrl", 32'(ctrl_a), 0);
        chk("a_relaunch_busy", 32'(busy_a), 1);
        chk("a_relaunch_freq", 32'(freq_a), 100);
        wait_done();

        chk("a_freq_left", 32'(q_freq_a.size()), 0);
        chk("b_freq_left", 32'(q_freq_b.size()), 0);
        chk("a_res_left", 32'(q_res_a.size()), 0);
        chk("b_res_left", 32'(q_res_b.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
